trivium_decrypt: RTL and testbench

TRIVIUM_DECRYPT -- requirements
Module: trivium_decrypt

---
 rtl/trivium_pkg.sv | 78 +++++++
 rtl/trivium_fifo.sv | 76 +++++++
 rtl/trivium_decrypt.sv | 120 ++++++++++++
 tb/tb_trivium_decrypt.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// Shared Trivium definitions: FSM states, status codes, register widths
// and the single-step / byte-step / keystream functions.
package trivium_pkg;

    localparam int KEY_LEN = 80;
    localparam int S1_W    = 93;
    localparam int S2_W    = 84;
    localparam int S3_W    = 111;

    typedef enum logic [2:0] {
        NO_KEY,
        GET_KEY,
        KEY_OK,
        INIT,
        RUN,
        ERROR
    } state_t;

    localparam logic [7:0] SIGN_IDLE  = 8'h00;
    localparam logic [7:0] SIGN_KEYOK = 8'h01;
    localparam logic [7:0] SIGN_INIT  = 8'h02;
    localparam logic [7:0] SIGN_RUN   = 8'h04;
    localparam logic [7:0] SIGN_ERROR = 8'h20;

    localparam logic [1:0] CND_READY = 2'b00;
    localparam logic [1:0] CND_BUSY  = 2'b01;
    localparam logic [1:0] CND_FULL  = 2'b10;
    localparam logic [1:0] CND_OVF   = 2'b11;

    typedef struct packed {
        logic [S3_W-1:0] s3;
        logic [S2_W-1:0] s2;
        logic [S1_W-1:0] s1;
    } triv_t;

    function automatic logic [7:0] sign_code(input state_t s);
        logic [7:0] c;
        case (s)
            KEY_OK:  c = SIGN_KEYOK;
            INIT:    c = SIGN_INIT;
            RUN:     c = SIGN_RUN;
            ERROR:   c = SIGN_ERROR;
            default: c = SIGN_IDLE;
        endcase
        return c;
    endfunction

    // One Trivium clock: new bits enter at index 0 of each register.
    function automatic triv_t triv_step(input triv_t s);
        logic  t1, t2, t3;
        triv_t n;
        t1 = s.s1[65] ^ s.s1[92] ^ (s.s1[90] & s.s1[91]) ^ s.s2[77];
        t2 = s.s2[68] ^ s.s2[83] ^ (s.s2[81] & s.s2[82]) ^ s.s3[86];
        t3 = s.s3[65] ^ s.s3[110] ^ (s.s3[108] & s.s3[109]) ^ s.s1[68];
        n.s1 = {s.s1[S1_W-2:0], t3};
        n.s2 = {s.s2[S2_W-2:0], t1};
        n.s3 = {s.s3[S3_W-2:0], t2};
        return n;
    endfunction

    function automatic triv_t triv_step8(input triv_t s);
        triv_t r;
        r = s;
        for (int i = 0; i < 8; i++) r = triv_step(r);
        return r;
    endfunction

    // Bit i is the keystream bit produced i steps after the current state.
    function automatic logic [7:0] ks_byte(input triv_t s);
        logic [7:0] z;
        for (int i = 0; i < 8; i++) begin
            z[i] = s.s1[65-i] ^ s.s1[92-i] ^ s.s2[68-i] ^
                   s.s2[83-i] ^ s.s3[65-i] ^ s.s3[110-i];
        end
        return z;
    endfunction

endpackage

// File: rtl/trivium_fifo.sv
// Synchronous plaintext byte FIFO with occupancy status.
// Ports: wr_en/wr_data push, rd_en pop, clr_ovf clears sticky overflow;
// rd_data is the head byte (00 when empty), not_empty, cnd status code.
module trivium_fifo
    import trivium_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int BURST = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    input  logic       clr_ovf,
    output logic [7:0] rd_data,
    output logic       not_empty,
    output logic [1:0] cnd
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] BURST_C = (AW+1)'(BURST);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   free;
    logic          ovf;
    logic          full;
    logic          empty;
    logic          do_wr;
    logic          do_rd;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign free  = DEPTH_C - count;
    assign do_rd = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (clr_ovf) ovf <= 1'b0;
            else if (wr_en && !do_wr) ovf <= 1'b1;
        end
    end

    assign rd_data   = empty ? 8'h00 : mem[rd_ptr];
    assign not_empty = !empty;

    always_comb begin
        cnd = CND_BUSY;
        if (ovf) cnd = CND_OVF;
        else if (full) cnd = CND_FULL;
        else if (free >= BURST_C) cnd = CND_READY;
    end

endmodule

// File: rtl/trivium_decrypt.sv
// Trivium stream decryptor: serial key load, warm-up, byte-wide decrypt.
// Ports: key/strob_key key load, cipher/cipher_vld input bytes, rd_en pops
// plain; plain_vld, fifo_cnd FIFO status, sign_reg registered state code.
module trivium_decrypt
    import trivium_pkg::*;
#(
    parameter int FIFO_DEPTH = 512,
    parameter int BURST_LEN  = 256,
    parameter int INIT_STEPS = 1153
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       strob_key,
    input  logic [7:0] cipher,
    input  logic       cipher_vld,
    input  logic       rd_en,
    output logic [7:0] plain,
    output logic       plain_vld,
    output logic [1:0] fifo_cnd,
    output logic [7:0] sign_reg
);

    localparam int IW = $clog2(INIT_STEPS + 1);

    state_t             state;
    triv_t              st;
    logic [KEY_LEN-1:0] key_reg;
    logic [6:0]         bit_cnt;
    logic [IW-1:0]      init_cnt;
    logic [7:0]         z;
    logic               wr_en;
    logic               clr_ovf;

    assign z       = ks_byte(st);
    // A rekey request wins over a byte arriving in the same cycle.
    assign wr_en   = (state == RUN) && cipher_vld && !strob_key;
    assign clr_ovf = (state == RUN) && strob_key;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= NO_KEY;
            sign_reg <= SIGN_IDLE;
            st       <= '0;
            key_reg  <= '0;
            bit_cnt  <= '0;
            init_cnt <= '0;
        end else begin
            sign_reg <= sign_code(state);
            case (state)
                NO_KEY: begin
                    if (cipher_vld) state <= ERROR;
                    else if (strob_key) begin
                        state   <= GET_KEY;
                        key_reg <= {key_reg[KEY_LEN-2:0], key};
                        bit_cnt <= 7'd1;
                    end
                end
                GET_KEY: begin
                    if (cipher_vld) state <= ERROR;
                    else if (strob_key) begin
                        key_reg <= {key_reg[KEY_LEN-2:0], key};
                        // Saturate just past 80 so long keys never alias to 80.
                        if (bit_cnt <= 7'(KEY_LEN)) bit_cnt <= bit_cnt + 7'd1;
                    end else if (bit_cnt == 7'(KEY_LEN)) state <= KEY_OK;
                    else state <= ERROR;
                end
                KEY_OK: begin
                    if (cipher_vld) state <= ERROR;
                    else begin
                        st.s1    <= {15'b0, key_reg[KEY_LEN-1:2]};
                        st.s2    <= '0;
                        st.s3    <= {3'b111, 108'b0};
                        init_cnt <= '0;
                        state    <= INIT;
                    end
                end
                INIT: begin
                    if (cipher_vld) state <= ERROR;
                    else begin
                        st <= triv_step(st);
                        if (init_cnt == IW'(INIT_STEPS - 1)) state <= RUN;
                        else init_cnt <= init_cnt + IW'(1);
                    end
                end
                RUN: begin
                    if (strob_key) begin
                        state   <= GET_KEY;
                        key_reg <= {key_reg[KEY_LEN-2:0], key};
                        bit_cnt <= 7'd1;
                    end else if (cipher_vld) st <= triv_step8(st);
                end
                ERROR: begin
                    state    <= NO_KEY;
                    st       <= '0;
                    key_reg  <= '0;
                    bit_cnt  <= '0;
                    init_cnt <= '0;
                end
                default: state <= NO_KEY;
            endcase
        end
    end

    trivium_fifo #(
        .DEPTH(FIFO_DEPTH),
        .BURST(BURST_LEN)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (cipher ^ z),
        .rd_en    (rd_en),
        .clr_ovf  (clr_ovf),
        .rd_data  (plain),
        .not_empty(plain_vld),
        .cnd      (fifo_cnd)
    );

endmodule

// File: tb/tb_trivium_decrypt.sv
// Self-checking bench for trivium_decrypt: key-length table, loopback
// against a bit-array Trivium model, FIFO full/overflow and reset cases.
module tb_trivium_decrypt;

    localparam int DEPTH = 512;
    localparam int BURST = 256;
    localparam int INITS = 1153;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key = 1'b0;
    logic       strob_key = 1'b0;
    logic [7:0] cipher = 8'h00;
    logic       cipher_vld = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] plain;
    logic       plain_vld;
    logic [1:0] fifo_cnd;
    logic [7:0] sign_reg;

    int checks = 0;
    int errors = 0;

    // Reference model: standard Trivium state s1..s288 as one array.
    bit         ms [1:288];
    logic [7:0] q [$];
    bit         ovf = 1'b0;

    trivium_decrypt #(
        .FIFO_DEPTH(DEPTH),
        .BURST_LEN (BURST),
        .INIT_STEPS(INITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .strob_key (strob_key),
        .cipher    (cipher),
        .cipher_vld(cipher_vld),
        .rd_en     (rd_en),
        .plain     (plain),
        .plain_vld (plain_vld),
        .fifo_cnd  (fifo_cnd),
        .sign_reg  (sign_reg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic m_step(output bit z);
        bit t1, t2, t3;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int j = 288; j >= 2; j--) ms[j] = ms[j-1];
        ms[1]   = t3;
        ms[94]  = t1;
        ms[178] = t2;
    endtask

    task automatic m_byte(output logic [7:0] zb);
        bit b;
        for (int i = 0; i < 8; i++) begin
            m_step(b);
            zb[i] = b;
        end
    endtask

    // Key bit k[79] is sent first; the first 78 received bits fill s78..s1,
    // IV is zero, s286..s288 are ones.
    task automatic m_key(input logic [79:0] k);
        bit b;
        for (int j = 1; j <= 288; j++) ms[j] = 1'b0;
        for (int j = 1; j <= 78; j++) ms[j] = k[j+1];
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
        repeat (INITS) m_step(b);
    endtask

    function automatic logic [1:0] m_cnd();
        if (ovf) return 2'b11;
        if (q.size() == DEPTH) return 2'b10;
        if (DEPTH - q.size() >= BURST) return 2'b00;
        return 2'b01;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        ovf = 1'b0;
    endtask

    task automatic send_key(input logic [79:0] k, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            strob_key = 1'b1;
            key = k[79 - (i % 80)];
            tick();
        end
        strob_key = 1'b0;
        key = 1'b0;
    endtask

    task automatic wait_run(input string nm);
        int n = 0;
        while (sign_reg !== 8'h04 && n < 5000) begin
            tick();
            n++;
        end
        chk(nm, sign_reg, 8'h04);
    endtask

    task automatic rekey(input logic [79:0] k, input string nm);
        send_key(k, 80);
        ovf = 1'b0;
        m_key(k);
        wait_run(nm);
    endtask

    // One RUN cycle: optional byte in, optional pop, model and status checks.
    task automatic cyc(input bit vld, input logic [7:0] p, input bit rd);
        logic [7:0] zb;
        bit         was_full;
        if (rd && q.size() > 0) chk("plain", plain, q[0]);
        if (vld) begin
            m_byte(zb);
            cipher = p ^ zb;
        end else cipher = 8'($urandom);
        cipher_vld = vld;
        rd_en = rd;
        tick();
        was_full = (q.size() == DEPTH);
        if (rd && q.size() > 0) void'(q.pop_front());
        if (vld) begin
            if (was_full && !rd) ovf = 1'b1;
            else q.push_back(p);
        end
        cipher_vld = 1'b0;
        rd_en = 1'b0;
        chk("plain_vld", plain_vld, q.size() != 0);
        chk("fifo_cnd", fifo_cnd, m_cnd());
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 2 * DEPTH) begin
            cyc(1'b0, 8'h00, 1'b1);
            n++;
        end
        chk("drained", plain_vld, 1'b0);
    endtask

    typedef struct {
        int         nbits;
        logic [7:0] sign1;
        logic [7:0] sign2;
    } kv_t;

    kv_t tbl [4];

    initial begin
        tbl[0] = '{79, 8'h20, 8'h00};
        tbl[1] = '{81, 8'h20, 8'h00};
        tbl[2] = '{1,  8'h20, 8'h00};
        tbl[3] = '{80, 8'h01, 8'h02};

        tick();
        do_reset();
        chk("rst_sign", sign_reg, 8'h00);
        chk("rst_vld", plain_vld, 1'b0);
        chk("rst_plain", plain, 8'h00);
        chk("rst_cnd", fifo_cnd, 2'b00);

        for (int t = 0; t < 4; t++) begin
            send_key({$urandom, $urandom, 16'($urandom)}, tbl[t].nbits);
            tick();
            chk("key_getkey", sign_reg, 8'h00);
            tick();
            chk("key_sign1", sign_reg, tbl[t].sign1);
            tick();
            chk("key_sign2", sign_reg, tbl[t].sign2);
            chk("key_nowr", plain_vld, 1'b0);
            do_reset();
        end

        rekey(80'h0, "run_loop");
        for (int i = 0; i < 256; i++) cyc(1'b1, 8'hA5, 1'b0);
        chk("loop_cnd256", fifo_cnd, 2'b00);
        drain();
        chk("loop_cnd_end", fifo_cnd, 2'b00);

        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'($urandom), 1'b0);
        chk("ovf_full", fifo_cnd, 2'b10);
        cyc(1'b1, 8'($urandom), 1'b0);
        chk("ovf_set", fifo_cnd, 2'b11);
        drain();
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'($urandom), i[0]);
        drain();
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom), 1'b0);
        chk("ovf_sticky", fifo_cnd, 2'b11);

        rekey({$urandom, $urandom, 16'($urandom)}, "run_rekey");
        chk("rekey_cnd", fifo_cnd, 2'b00);
        chk("rekey_keep", plain_vld, 1'b1);
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom), 8'($urandom), 1'($urandom));
        drain();

        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'($urandom), 1'b1);
            chk("full_rw_cnd", fifo_cnd, 2'b10);
        end
        drain();

        send_key({$urandom, $urandom, 16'($urandom)}, 80);
        repeat (20) tick();
        cipher_vld = 1'b1;
        tick();
        cipher_vld = 1'b0;
        tick();
        chk("init_vld_err", sign_reg, 8'h20);
        tick();
        chk("init_vld_idle", sign_reg, 8'h00);
        chk("init_vld_nowr", plain_vld, 1'b0);

        send_key({$urandom, $urandom, 16'($urandom)}, 80);
        repeat (602) tick();
        chk("mid_init", sign_reg, 8'h02);
        do_reset();
        chk("midrst_sign", sign_reg, 8'h00);
        chk("midrst_cnd", fifo_cnd, 2'b00);
        chk("midrst_vld", plain_vld, 1'b0);
        rekey({$urandom, $urandom, 16'($urandom)}, "run_after_rst");
        for (int i = 0; i < 40; i++) cyc(1'b1, 8'($urandom), 1'b0);
        drain();
        chk("final_cnd", fifo_cnd, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
